// File: rtl/lane_xform_fifo.sv
// lane_xform_fifo
//   Applies a runtime-selected per-lane transform to each accepted word and
//   buffers the result in a DEPTH-entry FIFO for a downstream consumer.
//   Transform modes (applied at write time, the mode is not stored):
//     0 pass, 1 invert lanes selected by INV_MASK, 2 invert all, 3 reverse lanes.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   IN_valid       upstream word valid
//   IN_data        upstream word, lane i = IN_data[i*LANE_W +: LANE_W]
//   IN_mode        transform for the word accepted this cycle
//   OUT_ready      block can accept a word (never while full or in reset)
//   OUT_valid      head entry valid
//   OUT_data       head entry
//   IN_ready       downstream accepts the head entry
//   OUT_count      current occupancy
//   OUT_almostFull OUT_count >= AFULL
module lane_xform_fifo #(
  parameter int               LANES    = 8,
  parameter int               LANE_W   = 1,
  parameter int               DEPTH    = 4,
  parameter logic [LANES-1:0] INV_MASK = LANES'(8'hAA),
  parameter int               AFULL    = DEPTH - 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IN_valid,
  input  logic [LANES*LANE_W-1:0]        IN_data,
  input  logic [1:0]                     IN_mode,
  output logic                           OUT_ready,
  output logic                           OUT_valid,
  output logic [LANES*LANE_W-1:0]        OUT_data,
  input  logic                           IN_ready,
  output logic [$clog2(DEPTH+1)-1:0]     OUT_count,
  output logic                           OUT_almostFull
);

  localparam int W  = LANES * LANE_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  function automatic logic [W-1:0] xform(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) begin
      case (m)
        2'd0:    r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        2'd1:    r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W] ^ {LANE_W{INV_MASK[i]}};
        2'd2:    r[i*LANE_W +: LANE_W] = ~d[i*LANE_W +: LANE_W];
        default: r[i*LANE_W +: LANE_W] = d[(LANES-1-i)*LANE_W +: LANE_W];
      endcase
    end
    return r;
  endfunction

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [W-1:0]  xf_word;

  // Status decodes registered state only; rst is folded into OUT_ready so a
  // word offered during the reset cycle is never accepted.
  assign OUT_ready      = (OUT_count != DEPTH_C) && !rst;
  assign OUT_valid      = (OUT_count != '0);
  assign OUT_data       = mem[rd_ptr];
  assign OUT_almostFull = (OUT_count >= AFULL_C);

  assign push    = IN_valid && OUT_ready;
  assign pop     = OUT_valid && IN_ready;
  assign xf_word = xform(IN_data, IN_mode);

  // Write stage: transformed word lands in storage (storage is not reset).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= xf_word;
    end
  end

  // Control: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      OUT_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   OUT_count <= OUT_count + CW'(1);
        2'b01:   OUT_count <= OUT_count - CW'(1);
        default: OUT_count <= OUT_count;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_xform_fifo.sv
// Bench for lane_xform_fifo. Two instances share all inputs:
//   dut_a: defaults (LANES=8, LANE_W=1, DEPTH=4, mask 8'hAA, AFULL=3)
//   dut_b: LANES=4, LANE_W=2, DEPTH=3 (mask 4'hA, AFULL=2)
// Each instance has its own reference queue and occupancy model.
module tb_lane_xform_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       in_ready;

  logic       ready_a, valid_a, afull_a;
  logic [7:0] data_a;
  logic [2:0] count_a;
  logic       ready_b, valid_b, afull_b;
  logic [7:0] data_b;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int ca = 0;
  int cb = 0;

  always #5 clk = ~clk;

  lane_xform_fifo dut_a (
    .clk(clk), .rst(rst), .IN_valid(in_valid), .IN_data(in_data), .IN_mode(in_mode),
    .OUT_ready(ready_a), .OUT_valid(valid_a), .OUT_data(data_a), .IN_ready(in_ready),
    .OUT_count(count_a), .OUT_almostFull(afull_a)
  );

  lane_xform_fifo #(.LANES(4), .LANE_W(2), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .IN_valid(in_valid), .IN_data(in_data), .IN_mode(in_mode),
    .OUT_ready(ready_b), .OUT_valid(valid_b), .OUT_data(data_b), .IN_ready(in_ready),
    .OUT_count(count_b), .OUT_almostFull(afull_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bit-level reference: output bit b belongs to lane b/lw.
  function automatic logic [7:0] ref_x(input logic [7:0] d, input logic [1:0] m,
                                        input int lanes, input int lw, input logic [7:0] mask);
    logic [7:0] r;
    int lane;
    for (int b = 0; b < 8; b++) begin
      lane = b / lw;
      case (m)
        2'd0:    r[b] = d[b];
        2'd1:    r[b] = d[b] ^ mask[lane];
        2'd2:    r[b] = ~d[b];
        default: r[b] = d[(lanes - 1 - lane) * lw + (b % lw)];
      endcase
    end
    return r;
  endfunction

  // One clock cycle: drive, check handshake/head before the edge, update the
  // models at the edge, check registered status after it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] m,
                     input logic r, input logic rs);
    logic pa, poa, pb, pob;
    in_valid = v; in_data = d; in_mode = m; in_ready = r; rst = rs;
    #1;
    pa  = v && (ca != 4) && !rs;
    poa = (ca != 0) && r && !rs;
    pb  = v && (cb != 3) && !rs;
    pob = (cb != 0) && r && !rs;
    chk("ready_a", 32'(ready_a), 32'((ca != 4) && !rs));
    chk("ready_b", 32'(ready_b), 32'((cb != 3) && !rs));
    if (poa) chk("data_a", 32'(data_a), 32'(qa[0]));
    if (pob) chk("data_b", 32'(data_b), 32'(qb[0]));
    @(posedge clk);
    if (rs) begin
      qa.delete(); qb.delete(); ca = 0; cb = 0;
    end else begin
      if (poa) void'(qa.pop_front());
      if (pob) void'(qb.pop_front());
      if (pa) qa.push_back(ref_x(d, m, 8, 1, 8'hAA));
      if (pb) qb.push_back(ref_x(d, m, 4, 2, 8'hAA));
      ca = ca + int'(pa) - int'(poa);
      cb = cb + int'(pb) - int'(pob);
    end
    #1;
    chk("count_a", 32'(count_a), 32'(ca));
    chk("count_b", 32'(count_b), 32'(cb));
    chk("valid_a", 32'(valid_a), 32'(ca != 0));
    chk("valid_b", 32'(valid_b), 32'(cb != 0));
    chk("afull_a", 32'(afull_a), 32'(ca >= 3));
    chk("afull_b", 32'(afull_b), 32'(cb >= 2));
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{d: 8'h0F, m: 2'd1, ea: 8'hA5, eb: 8'hC3};
    vecs[1] = '{d: 8'h0F, m: 2'd2, ea: 8'hF0, eb: 8'hF0};
    vecs[2] = '{d: 8'h01, m: 2'd3, ea: 8'h80, eb: 8'h40};
    vecs[3] = '{d: 8'h3C, m: 2'd0, ea: 8'h3C, eb: 8'h3C};
    vecs[4] = '{d: 8'hE4, m: 2'd3, ea: 8'h27, eb: 8'h1B};
    vecs[5] = '{d: 8'hE4, m: 2'd1, ea: 8'h4E, eb: 8'h28};

    // Reset
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_a", 32'(ready_a), 32'd1);

    // Transform table: push, then check head one edge later, then pop
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, vecs[i].d, vecs[i].m, 1'b0, 1'b0);
      chk("vec_data_a", 32'(data_a), 32'(vecs[i].ea));
      chk("vec_data_b", 32'(data_b), 32'(vecs[i].eb));
      cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    end

    // Fill with IN_ready=0; a 5th word is dropped
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 2'd0, 1'b0, 1'b0);
      chk("fill_count_a", 32'(count_a), 32'(i + 1));
    end
    chk("full_afull_a", 32'(afull_a), 32'd1);
    cyc(1'b1, 8'h77, 2'd0, 1'b0, 1'b0);
    chk("drop_count_a", 32'(count_a), 32'd4);

    // Full with simultaneous pop: no bypass, count 4 -> 3, then holds
    cyc(1'b1, 8'h55, 2'd0, 1'b1, 1'b0);
    chk("full_pop_count_a", 32'(count_a), 32'd3);
    cyc(1'b1, 8'h66, 2'd2, 1'b1, 1'b0);
    chk("pushpop_count_a", 32'(count_a), 32'd3);

    // Drain
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    chk("drained_valid_a", 32'(valid_a), 32'd0);
    chk("drained_valid_b", 32'(valid_b), 32'd0);

    // Wrap-around streaming with IN_ready toggling every cycle
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 8'($urandom), 2'($urandom_range(0, 3)), 1'(i % 2), 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    chk("wrap_empty_b", 32'(count_b), 32'd0);

    // Reset mid-operation at count 2, with push and pop offered
    cyc(1'b1, 8'h21, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'h23, 2'd0, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid_a", 32'(valid_a), 32'd0);
    chk("mid_rst_count_a", 32'(count_a), 32'd0);
    chk("mid_rst_ready_a", 32'(ready_a), 32'd1);
    cyc(1'b1, 8'h5A, 2'd0, 1'b0, 1'b0);
    chk("after_rst_data_a", 32'(data_a), 32'h5A);
    chk("after_rst_valid_a", 32'(valid_a), 32'd1);
    cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
